// File: rtl/fft_pkg.sv
// Shared constants and complex-word helpers for the radix-2 butterfly PE.
// Complex words are packed {re, im}; each component is signed.
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 8;
    localparam int CW_MAX = 32;

    typedef logic [2*CW_MAX-1:0]        cword_t;
    typedef logic signed [CW_MAX-1:0]   comp_t;

    // Helpers run at the widest supported width; dw selects the live component width.
    function automatic comp_t cw_re(input cword_t w, input int dw);
        cword_t t;
        t = w << (2*CW_MAX - 2*dw);
        return comp_t'($signed(t) >>> (2*CW_MAX - dw));
    endfunction

    function automatic comp_t cw_im(input cword_t w, input int dw);
        cword_t t;
        t = w << (2*CW_MAX - dw);
        return comp_t'($signed(t) >>> (2*CW_MAX - dw));
    endfunction

    function automatic cword_t cw_pack(input comp_t re, input comp_t im, input int dw);
        cword_t mask;
        mask = (cword_t'(1'b1) << dw) - cword_t'(1'b1);
        return ((cword_t'(re) & mask) << dw) | (cword_t'(im) & mask);
    endfunction

    // Half an LSB of the Q1.(dw-1) result, added before the product shift.
    function automatic cword_t rnd_const(input int dw);
        return cword_t'(1'b1) << (dw - 2);
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Complex multiply P = B*W with one output register stage.
// Products are rounded back to Q1.(DW-1) and kept at DW+1 bits, unsaturated.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                i_clk,
    input  logic [2*DW-1:0]     i_b,
    input  logic [2*DW-1:0]     i_w,
    output logic signed [DW:0]  o_pr,
    output logic signed [DW:0]  o_pi
);

    logic signed [DW-1:0]   w_br, w_bi, w_wr, w_wi;
    logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [2*DW:0]   w_rnd, w_pr_full, w_pi_full;
    logic signed [DW:0]     r_pr, r_pi;

    assign w_br = DW'(cw_re(cword_t'(i_b), DW));
    assign w_bi = DW'(cw_im(cword_t'(i_b), DW));
    assign w_wr = DW'(cw_re(cword_t'(i_w), DW));
    assign w_wi = DW'(cw_im(cword_t'(i_w), DW));

    assign w_rr  = w_br * w_wr;
    assign w_ii  = w_bi * w_wi;
    assign w_ri  = w_br * w_wi;
    assign w_ir  = w_bi * w_wr;
    assign w_rnd = $signed((2*DW+1)'(rnd_const(DW)));

    assign w_pr_full = $signed({w_rr[2*DW-1], w_rr}) - $signed({w_ii[2*DW-1], w_ii}) + w_rnd;
    assign w_pi_full = $signed({w_ri[2*DW-1], w_ri}) + $signed({w_ir[2*DW-1], w_ir}) + w_rnd;

    // Product register: shift by DW-1 back to component scale.
    always_ff @(posedge i_clk) begin
        r_pr <= (DW+1)'(w_pr_full >>> (DW-1));
        r_pi <= (DW+1)'(w_pi_full >>> (DW-1));
    end

    assign o_pr = r_pr;
    assign o_pi = r_pi;

endmodule

// File: rtl/fft_bfly_pe.sv
// Radix-2 DIT butterfly PE: reads (A,B,W), writes A+BW / A-BW back in place 3 cycles later.
// Build option BFLY_SCALE_EN: halve each result with rounding instead of saturating.
module fft_bfly_pe
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [AW-1:0]   in_addr_a,
    input  logic [AW-1:0]   in_addr_b,
    input  logic [AW-1:0]   in_addr_w,
    output logic [AW-1:0]   mem_rd_addr_a,
    output logic [AW-1:0]   mem_rd_addr_b,
    input  logic [2*DW-1:0] mem_rd_data_a,
    input  logic [2*DW-1:0] mem_rd_data_b,
    output logic [AW-1:0]   tw_addr,
    input  logic [2*DW-1:0] tw_data,
    output logic            mem_wr_en,
    output logic [AW-1:0]   mem_wr_addr_a,
    output logic [AW-1:0]   mem_wr_addr_b,
    output logic [2*DW-1:0] mem_wr_data_a,
    output logic [2*DW-1:0] mem_wr_data_b,
    output logic            busy,
    input  logic            clr_ovf,
    output logic            ovf
);

    logic                   r_v1, r_v2, r_v3;
    logic [AW-1:0]          r_addr_a1, r_addr_b1, r_addr_a2, r_addr_b2;
    logic [AW-1:0]          r_wr_addr_a, r_wr_addr_b;
    logic [2*DW-1:0]        r_ad2, r_wr_data_a, r_wr_data_b;
    logic                   r_ovf_ev, r_ovf;
    logic signed [DW:0]     w_pr, w_pi;
    logic signed [DW-1:0]   w_a_re, w_a_im;
    logic signed [DW+1:0]   w_s_re, w_s_im, w_d_re, w_d_im;
    logic                   w_ovf_any;

    function automatic logic out_of_range(input logic signed [DW+1:0] x);
        return x != (DW+2)'(DW'(x));
    endfunction

`ifdef BFLY_SCALE_EN
    localparam logic signed [DW+1:0] RND_HALF = (DW+2)'(1'b1);

    function automatic logic signed [DW-1:0] reduce(input logic signed [DW+1:0] x);
        return DW'((x + RND_HALF) >>> 1);
    endfunction
`else
    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] reduce(input logic signed [DW+1:0] x);
        if (out_of_range(x)) begin
            return x[DW+1] ? SAT_MIN : SAT_MAX;
        end else begin
            return DW'(x);
        end
    endfunction
`endif

    assign mem_rd_addr_a = in_addr_a;
    assign mem_rd_addr_b = in_addr_b;
    assign tw_addr       = in_addr_w;

    fft_cmul #(.DW(DW)) u_cmul (
        .i_clk (clk),
        .i_b   (mem_rd_data_b),
        .i_w   (tw_data),
        .o_pr  (w_pr),
        .o_pi  (w_pi)
    );

    assign w_a_re = DW'(cw_re(cword_t'(r_ad2), DW));
    assign w_a_im = DW'(cw_im(cword_t'(r_ad2), DW));
    assign w_s_re = (DW+2)'(w_a_re) + (DW+2)'(w_pr);
    assign w_s_im = (DW+2)'(w_a_im) + (DW+2)'(w_pi);
    assign w_d_re = (DW+2)'(w_a_re) - (DW+2)'(w_pr);
    assign w_d_im = (DW+2)'(w_a_im) - (DW+2)'(w_pi);
    assign w_ovf_any = out_of_range(w_s_re) | out_of_range(w_s_im) |
                       out_of_range(w_d_re) | out_of_range(w_d_im);

    // Address and A-operand delay alongside the multiplier stage.
    always_ff @(posedge clk) begin
        r_addr_a1 <= in_addr_a;
        r_addr_b1 <= in_addr_b;
        r_addr_a2 <= r_addr_a1;
        r_addr_b2 <= r_addr_b1;
        r_ad2     <= mem_rd_data_a;
    end

    // Valid pipeline, held write-back registers and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_wr_addr_a <= {AW{1'b0}};
            r_wr_addr_b <= {AW{1'b0}};
            r_wr_data_a <= {(2*DW){1'b0}};
            r_wr_data_b <= {(2*DW){1'b0}};
            r_ovf_ev    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_v1     <= in_valid;
            r_v2     <= r_v1;
            r_v3     <= r_v2;
            r_ovf_ev <= r_v2 & w_ovf_any;
            if (r_v2) begin
                r_wr_addr_a <= r_addr_a2;
                r_wr_addr_b <= r_addr_b2;
                r_wr_data_a <= (2*DW)'(cw_pack(comp_t'(reduce(w_s_re)), comp_t'(reduce(w_s_im)), DW));
                r_wr_data_b <= (2*DW)'(cw_pack(comp_t'(reduce(w_d_re)), comp_t'(reduce(w_d_im)), DW));
            end
            if (r_v3 && r_ovf_ev) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign mem_wr_en     = r_v3;
    assign mem_wr_addr_a = r_wr_addr_a;
    assign mem_wr_addr_b = r_wr_addr_b;
    assign mem_wr_data_a = r_wr_data_a;
    assign mem_wr_data_b = r_wr_data_b;
    assign busy          = r_v1 | r_v2 | r_v3;
    assign ovf           = r_ovf;

endmodule

// File: tb/tb_fft_bfly_pe.sv
// Directed bench for fft_bfly_pe: issued triples push expected write-backs, a monitor pops and compares.
// Expected data follows the BFLY_SCALE_EN build option.
`timescale 1ns/1ps
module tb_fft_bfly_pe;

    localparam int DW = 16;
    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0]   a;
        logic [AW-1:0]   b;
        logic [2*DW-1:0] da;
        logic [2*DW-1:0] db;
        int              c;
    } exp_t;

`ifdef BFLY_SCALE_EN
    localparam logic [31:0] E_W1_A  = 32'h0C00_0000;
    localparam logic [31:0] E_W1_B  = 32'h0400_0000;
    localparam logic [31:0] E_WJ_A  = 32'h0000_FC00;
    localparam logic [31:0] E_WJ_B  = 32'h0000_0400;
    localparam logic [31:0] E_SAT_A = 32'h7000_0000;
    localparam logic [31:0] E_SAT_B = 32'h0001_0000;
`else
    localparam logic [31:0] E_W1_A  = 32'h1800_0000;
    localparam logic [31:0] E_W1_B  = 32'h0800_0000;
    localparam logic [31:0] E_WJ_A  = 32'h0000_F800;
    localparam logic [31:0] E_WJ_B  = 32'h0000_0800;
    localparam logic [31:0] E_SAT_A = 32'h7FFF_0000;
    localparam logic [31:0] E_SAT_B = 32'h0001_0000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [AW-1:0]   in_addr_a = 8'h00;
    logic [AW-1:0]   in_addr_b = 8'h00;
    logic [AW-1:0]   in_addr_w = 8'h00;
    logic            clr_ovf = 1'b0;
    logic [AW-1:0]   mem_rd_addr_a, mem_rd_addr_b, tw_addr;
    logic [AW-1:0]   mem_wr_addr_a, mem_wr_addr_b;
    logic [2*DW-1:0] rd_a, rd_b, twd;
    logic [2*DW-1:0] mem_wr_data_a, mem_wr_data_b;
    logic            mem_wr_en, busy, ovf;

    logic [2*DW-1:0] ram [0:(1<<AW)-1];
    logic [2*DW-1:0] rom [0:(1<<AW)-1];
    exp_t            q[$];
    exp_t            mon_e;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [4:0]      pat;

    fft_bfly_pe #(.DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_addr_a     (in_addr_a),
        .in_addr_b     (in_addr_b),
        .in_addr_w     (in_addr_w),
        .mem_rd_addr_a (mem_rd_addr_a),
        .mem_rd_addr_b (mem_rd_addr_b),
        .mem_rd_data_a (rd_a),
        .mem_rd_data_b (rd_b),
        .tw_addr       (tw_addr),
        .tw_data       (twd),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr_a (mem_wr_addr_a),
        .mem_wr_addr_b (mem_wr_addr_b),
        .mem_wr_data_a (mem_wr_data_a),
        .mem_wr_data_b (mem_wr_data_b),
        .busy          (busy),
        .clr_ovf       (clr_ovf),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    // Cycle counter and synchronous-read RAM/ROM models (data one cycle after address).
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_a <= ram[mem_rd_addr_a];
        rd_b <= ram[mem_rd_addr_b];
        twd  <= rom[tw_addr];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Burst data: A=16k, B=0x0100, W~1, so A'=16k+256 and B'=16k-256 (halved when scaling).
    function automatic logic [2*DW-1:0] exp_burst(input int k, input bit upper);
        int v;
        v = upper ? (16*k + 256) : (16*k - 256);
`ifdef BFLY_SCALE_EN
        v = (v + 1) >>> 1;
`endif
        return {v[15:0], 16'h0000};
    endfunction

    task automatic drive(input logic v, input bit push, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] w, input logic [2*DW-1:0] ea, input logic [2*DW-1:0] eb);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_addr_a = a;
        in_addr_b = b;
        in_addr_w = w;
        if (v && push) q.push_back('{a, b, ea, eb, cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: every write strobe must match the oldest expected entry, including its cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mem_wr_en) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write a=%h b=%h in cycle %0d, required none",
                             mem_wr_addr_a, mem_wr_addr_b, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("wr_addr_data_cycle",
                        {mem_wr_addr_a, mem_wr_addr_b, mem_wr_data_a, mem_wr_data_b, cyc},
                        {mon_e.a, mon_e.b, mon_e.da, mon_e.db, mon_e.c});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram[i] = 32'h0000_0000;
            rom[i] = 32'h0000_0000;
        end
        rom[0]  = 32'h7FFF_0000;
        rom[64] = 32'h0000_8000;
        ram[2]  = 32'h1000_0000;
        ram[3]  = 32'h0800_0000;
        ram[5]  = 32'h0800_0000;
        ram[16] = 32'h7000_0000;
        ram[17] = 32'h7000_0000;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_wr_addr", {mem_wr_addr_a, mem_wr_addr_b}, 16'h0000);
        chk("rst_wr_data", {mem_wr_data_a, mem_wr_data_b}, 64'h0);

        // W=1 then W=-j, back to back
        drive(1'b1, 1'b1, 8'h02, 8'h03, 8'h00, E_W1_A, E_W1_B);
        drive(1'b1, 1'b1, 8'h04, 8'h05, 8'h40, E_WJ_A, E_WJ_B);
        idle(5);
        @(negedge clk);
        chk("ovf_clean", ovf, 1'b0);

        // Saturation: ovf rises the cycle after the write, then clears
        drive(1'b1, 1'b1, 8'h10, 8'h11, 8'h00, E_SAT_A, E_SAT_B);
        idle(3);
        @(negedge clk);
        chk("ovf_at_write", ovf, 1'b0);
        idle(1);
        @(negedge clk);
        chk("ovf_set", ovf, 1'b1);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", ovf, 1'b0);

        // Clear coinciding with a new overflow event: set wins
        drive(1'b1, 1'b1, 8'h10, 8'h11, 8'h00, E_SAT_A, E_SAT_B);
        idle(2);
        @(posedge clk); #1 in_valid = 1'b0; clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", ovf, 1'b1);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared2", ovf, 1'b0);

        // Stage-1 sweep burst
        for (int k = 0; k < 128; k++) begin
            ram[2*k]   = {16'(16*k), 16'h0000};
            ram[2*k+1] = 32'h0100_0000;
        end
        for (int k = 0; k < 128; k++) begin
            drive(1'b1, 1'b1, AW'(2*k), AW'(2*k+1), 8'h00, exp_burst(k, 1'b1), exp_burst(k, 1'b0));
        end
        idle(3);
        @(negedge clk);
        chk("busy_last_plus3", busy, 1'b1);
        idle(1);
        @(negedge clk);
        chk("busy_last_plus4", busy, 1'b0);
        idle(2);

        // Reset while two triples are in flight
        drive(1'b1, 1'b0, 8'h20, 8'h21, 8'h00, 32'h0, 32'h0);
        @(posedge clk); #1 in_addr_a = 8'h22; in_addr_b = 8'h23; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", busy, 1'b0);
        idle(1);
        @(negedge clk);
        chk("no_wr_t3", mem_wr_en, 1'b0);
        idle(1);
        @(negedge clk);
        chk("no_wr_t4", mem_wr_en, 1'b0);
        idle(2);

        // Bubble pattern 1,0,1,1,0
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            drive(pat[i], 1'b1, AW'(2*(10+i)), AW'(2*(10+i)+1), 8'h00,
                  exp_burst(10+i, 1'b1), exp_burst(10+i, 1'b0));
        end
        idle(6);
        chk("sb_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
